lmfe_sram_arb: RTL
==================

LMFE_SRAM_ARB -- requirements
Module: lmfe_sram_arb

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning the SRAM address width.
REQ-002 The block SHALL have parameter DW, default 8, meaning the SRAM data width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 3, meaning the maximum number of consecutive cycles a buffered write may be blocked by reads.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The ports SHALL be, in order:
- clk  in  1  clock.
- RST  in  1  asynchronous active-low reset.
- wr_req  in  1  write request.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_rdy  out  1  write buffer can accept.
- rd_req  in  1  read request.
- rd_addr  in  AW  read address.
- rd_gnt  out  1  read accepted this cycle.
- rd_valid  out  1  read data valid.
- rd_data  out  DW  read data.
- A  out  AW  SRAM address.
- D  out  DW  SRAM write data.
- CEN  out  1  SRAM chip enable, active-low.
- WEN  out  1  SRAM write enable, active-low.
- Q  in  DW  SRAM read data, valid the cycle after access.
- wbuf_cnt  out  2  buffered write count.

Function
REQ-006 The block SHALL post writes into a 2-entry FIFO write buffer; a write is accepted when wr_req=1 and wr_rdy=1 at a clk edge.
REQ-007 wr_rdy SHALL equal (wbuf_cnt<2), derived from registered state only.
REQ-008 Read forwarding: when rd_req=1 and rd_addr matches a valid buffer entry, the block SHALL assert rd_gnt=1 in the same cycle, without an SRAM read, and take the data from the youngest matching entry.
REQ-009 When rd_req=1 with no buffer match and the buffer is empty, the block SHALL assert rd_gnt=1 and issue an SRAM read: CEN=0, WEN=1, A=rd_addr.
REQ-010 When rd_req=1 with no buffer match and the buffer is non-empty, the read SHALL win unless wbuf_cnt==2 or starve_cnt==STARVE_MAX. In either of those cases the oldest entry SHALL drain and rd_gnt SHALL be 0.
REQ-011 A drain SHALL drive CEN=0, WEN=0, A/D from the oldest entry, and pop that entry at the clk edge. A drain SHALL also occur in any cycle where the SRAM is not used by a read, including forwarded-read cycles.
REQ-012 starve_cnt SHALL increment, saturating at STARVE_MAX, on each cycle where the buffer is non-empty and a read blocks the drain. It SHALL clear on every drain.
REQ-013 With no SRAM access, the SRAM outputs SHALL be CEN=1, WEN=1, A=0, D=0.
REQ-014 rd_valid SHALL assert exactly one cycle after each rd_gnt.
REQ-015 When rd_valid=1, rd_data SHALL be Q for an SRAM read, or the registered forwarded value for a forwarded read. When rd_valid=0, rd_data SHALL be 0.
REQ-016 A write accepted in the same cycle as a read to the same address SHALL be ordered after that read, so the read returns the prior value.
REQ-017 Accept and drain in the same cycle SHALL leave wbuf_cnt unchanged.
REQ-018 A write to an address already buffered SHALL create a new entry with no merging; the drain order SHALL be preserved.
REQ-019 rd_gnt, A, D, CEN and WEN SHALL be combinational from the inputs and registered state; all other outputs SHALL be registered.

Reset
REQ-020 On RST=0 the block SHALL asynchronously empty the buffer (wbuf_cnt=0) and clear starve_cnt and the rd_valid/forward registers. All outputs SHALL then read: wr_rdy=1, rd_gnt=0, rd_valid=0, rd_data=0, CEN=1, WEN=1, A=0, D=0.
REQ-021 Reset mid-operation SHALL discard buffered writes and any in-flight read return.

Structure
REQ-022 AW, DW, STARVE_MAX defaults and the active-low SRAM control constants (SRAM_ON=0, SRAM_OFF=1) SHALL reside in shared package lmfe_pkg.
REQ-023 The write buffer with its address compare and youngest-match selection SHALL be sub-module lmfe_wbuf; arbitration and the starve counter SHALL stay in lmfe_sram_arb.

Verification
REQ-024 Write 0x3A to addr 5, no reads -> next cycle CEN=0, WEN=0, A=5, D=0x3A; wbuf_cnt returns to 0.
REQ-025 Buffer holds addr 7=0x11 then addr 7=0x22; read addr 7 -> rd_gnt same cycle, CEN not used for the read, rd_valid next cycle with rd_data=0x22.
REQ-026 Buffer holds 1 entry, rd_req held high on non-matching addresses -> reads granted for 3 cycles, 4th cycle drains with rd_gnt=0, then reads resume.
REQ-027 Fill buffer to 2, continuous wr_req and reads -> wr_rdy=0 while full, drain forced each full cycle, no write lost; final SRAM contents match write order.
REQ-028 Read addr 9 (SRAM=0x55) with simultaneous write addr 9=0x66 -> rd_data=0x55; a later read returns 0x66.
REQ-029 Assert RST=0 with 2 entries buffered and rd_valid pending -> outputs immediately at reset values, wbuf_cnt=0, discarded writes never reach the SRAM.

Source files
------------

// File: rtl/lmfe_pkg.sv
// Shared defaults and encodings for the SRAM write-buffer arbiter.
// SRAM controls are active-low, so ON is the asserted (0) level.
package lmfe_pkg;
  localparam int AW_DEF         = 10;
  localparam int DW_DEF         = 8;
  localparam int STARVE_MAX_DEF = 3;

  localparam logic SRAM_ON  = 1'b0;
  localparam logic SRAM_OFF = 1'b1;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_DRAIN = 2'd2
  } sram_op_e;
endpackage

// File: rtl/lmfe_sram_arb_if.sv
// Single-port SRAM macro bus: the arbiter is master, the macro is slave.
// Q carries read data one cycle after a CEN=0/WEN=1 access.
interface lmfe_sram_arb_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic          CEN;
  logic          WEN;

  modport master (output A, output D, output CEN, output WEN, input Q);
  modport slave  (input A, input D, input CEN, input WEN, output Q);
endinterface

// File: rtl/lmfe_wbuf.sv
// Two-entry posted-write FIFO (entry 0 oldest) with address compare for forwarding.
// Push/pop take effect at the clock edge; match result is combinational on current contents.
module lmfe_wbuf
  import lmfe_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic [AW-1:0] cmp_addr_i,
  output logic          hit_o,
  output logic [DW-1:0] hit_data_o,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic [1:0]    cnt_o
);
  logic [AW-1:0] a0_q, a0_d, a1_q, a1_d;
  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          hit0, hit1;

  // Entry 1 is younger, so it wins when both hold the same address.
  assign hit0        = (cnt_q != 2'd0) && (a0_q == cmp_addr_i);
  assign hit1        = (cnt_q == 2'd2) && (a1_q == cmp_addr_i);
  assign hit_o       = hit0 || hit1;
  assign hit_data_o  = hit1 ? d1_q : d0_q;
  assign head_addr_o = a0_q;
  assign head_data_o = d0_q;
  assign cnt_o       = cnt_q;

  always_comb begin
    a0_d  = a0_q;
    d0_d  = d0_q;
    a1_d  = a1_q;
    d1_d  = d1_q;
    if (pop_i) begin
      a0_d = a1_q;
      d0_d = d1_q;
    end
    if (push_i) begin
      if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop_i)) begin
        a0_d = push_addr_i;
        d0_d = push_data_i;
      end else begin
        a1_d = push_addr_i;
        d1_d = push_data_i;
      end
    end
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q  <= '0;
      d0_q  <= '0;
      a1_q  <= '0;
      d1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      a0_q  <= a0_d;
      d0_q  <= d0_d;
      a1_q  <= a1_d;
      d1_q  <= d1_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/lmfe_sram_arb.sv
// Read/write arbiter for a single-port SRAM with posted writes and read forwarding.
// Reads are granted combinationally and return one cycle later; wr_rdy drops while the buffer is full.
module lmfe_sram_arb
  import lmfe_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_rdy,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  output logic          CEN,
  output logic          WEN,
  input  logic [DW-1:0] Q,
  output logic [1:0]    wbuf_cnt
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic          hit, push, pop, fwd;
  logic [DW-1:0] hit_data, head_data;
  logic [AW-1:0] head_addr;
  logic [1:0]    cnt;
  sram_op_e      op;
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_valid_q, fwd_sel_q;
  logic [DW-1:0] fwd_q, fwd_d;

  lmfe_wbuf #(.AW(AW), .DW(DW)) u_wbuf (
    .clk         (clk),
    .rst_n       (RST),
    .push_i      (push),
    .push_addr_i (wr_addr),
    .push_data_i (wr_data),
    .pop_i       (pop),
    .cmp_addr_i  (rd_addr),
    .hit_o       (hit),
    .hit_data_o  (hit_data),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .cnt_o       (cnt)
  );

  assign wr_rdy = (cnt != 2'd2);
  assign push   = wr_req && wr_rdy;
  assign fwd    = rd_req && hit;

  // A missing read beats the drain unless the buffer is full or the drain has waited too long.
  always_comb begin
    op = OP_IDLE;
    if (rd_req && !hit &&
        (cnt == 2'd0 || (cnt != 2'd2 && starve_q != STARVE_LIM))) begin
      op = OP_READ;
    end else if (cnt != 2'd0) begin
      op = OP_DRAIN;
    end
  end

  assign pop    = (op == OP_DRAIN);
  assign rd_gnt = fwd || (op == OP_READ);
  assign CEN    = (op == OP_IDLE) ? SRAM_OFF : SRAM_ON;
  assign WEN    = pop ? SRAM_ON : SRAM_OFF;
  assign D      = pop ? head_data : '0;

  always_comb begin
    A = '0;
    if (op == OP_READ) begin
      A = rd_addr;
    end else if (op == OP_DRAIN) begin
      A = head_addr;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (op == OP_READ && cnt != 2'd0 && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign fwd_d = fwd ? hit_data : '0;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
      fwd_sel_q  <= 1'b0;
      fwd_q      <= '0;
    end else begin
      starve_q   <= starve_d;
      rd_valid_q <= rd_gnt;
      fwd_sel_q  <= fwd;
      fwd_q      <= fwd_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? (fwd_sel_q ? fwd_q : Q) : '0;
  assign wbuf_cnt = cnt;
endmodule
